id_ex_stage: RTL

Decode-to-execute pipeline stage of the RV32I core, directly upstream of the ALU. Accepts one decoded instruction per cycle from ID, turns opcode/funct3/funct7 into the 4-bit ALU control code, selects and forwards operands, and registers them into the ALU input set. Also holds the destination info that EX/MEM needs and inserts load-use bubbles.

---
 rtl/rv_pkg.sv | 59 +++++
 rtl/alu_dec.sv | 69 ++++++
 rtl/id_ex_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// RV32I shared constants: ALU codes, opcodes, funct3 codes, operand selects.
package rv_pkg;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_XOR  = 4'h2;
    localparam logic [3:0] ALU_ANDN = 4'h3;
    localparam logic [3:0] ALU_ORN  = 4'h4;
    localparam logic [3:0] ALU_ADD  = 4'h5;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLT  = 4'h7;
    localparam logic [3:0] ALU_SLTU = 4'h8;
    localparam logic [3:0] ALU_SLL  = 4'h9;
    localparam logic [3:0] ALU_SRL  = 4'hA;
    localparam logic [3:0] ALU_SRA  = 4'hB;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} b_sel_e;

    function automatic logic [3:0] f3_to_alu(
        input logic [2:0] f3,
        input logic       sub,
        input logic       sra
    );
        logic [3:0] r;
        r = ALU_ADD;
        unique case (f3)
            F3_ADD:  r = sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  r = ALU_SLL;
            F3_SLT:  r = ALU_SLT;
            F3_SLTU: r = ALU_SLTU;
            F3_XOR:  r = ALU_XOR;
            F3_SRL:  r = sra ? ALU_SRA : ALU_SRL;
            F3_OR:   r = ALU_OR;
            F3_AND:  r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational decode of opcode/funct3/funct7_5 into ALU control and
// operand-select information.
module alu_dec
    import rv_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_alu_ctrl,
    output logic [1:0] o_a_sel,
    output logic [1:0] o_b_sel,
    output logic       o_rd_we,
    output logic       o_uses_rs2,
    output logic       o_is_load,
    output logic       o_illegal
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_a_sel    = A_RS1;
        o_b_sel    = B_IMM;
        o_rd_we    = 1'b0;
        o_uses_rs2 = 1'b0;
        o_is_load  = 1'b0;
        o_illegal  = 1'b0;
        unique case (i_opcode)
            OPC_OP: begin
                o_alu_ctrl = f3_to_alu(i_funct3, i_funct7_5, i_funct7_5);
                o_b_sel    = B_RS2;
                o_rd_we    = 1'b1;
                o_uses_rs2 = 1'b1;
            end
            // Immediate forms never subtract; bit 30 only selects SRAI.
            OPC_OPIMM: begin
                o_alu_ctrl = f3_to_alu(i_funct3, 1'b0, i_funct7_5);
                o_rd_we    = 1'b1;
            end
            OPC_LUI: begin
                o_a_sel = A_ZERO;
                o_rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                o_a_sel = A_PC;
                o_rd_we = 1'b1;
            end
            OPC_LOAD: begin
                o_rd_we   = 1'b1;
                o_is_load = 1'b1;
            end
            OPC_STORE: begin
                o_uses_rs2 = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                o_a_sel = A_PC;
                o_b_sel = B_FOUR;
                o_rd_we = 1'b1;
            end
            OPC_BRANCH: begin
                o_alu_ctrl = ALU_SUB;
                o_b_sel    = B_RS2;
                o_uses_rs2 = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register stage: decode, operand select/forward, load-use bubble.
// Build option RVCORE_FWD_EN enables forwarding muxes and the interlock.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int XLEN   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7_5,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_exm_we,
    input  logic [REG_AW-1:0] i_exm_rd,
    input  logic [XLEN-1:0]   i_exm_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic              o_valid,
    output logic [3:0]        o_alu_ctrl,
    output logic [XLEN-1:0]   o_dataa,
    output logic [XLEN-1:0]   o_datab,
    output logic [XLEN-1:0]   o_store_data,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_rd_we,
    output logic              o_is_load,
    output logic              o_illegal
);

    logic [3:0]      w_alu_ctrl;
    logic [1:0]      w_a_sel;
    logic [1:0]      w_b_sel;
    logic            w_rd_we;
    logic            w_uses_rs2;
    logic            w_is_load;
    logic            w_illegal;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b_raw;
    logic [XLEN-1:0] w_b;
    logic            w_hazard;
    logic            w_accept;

    logic              r_valid;
    logic [3:0]        r_alu_ctrl;
    logic [XLEN-1:0]   r_dataa;
    logic [XLEN-1:0]   r_datab;
    logic [XLEN-1:0]   r_store_data;
    logic [REG_AW-1:0] r_rd;
    logic              r_rd_we;
    logic              r_is_load;
    logic              r_illegal;

    alu_dec u_dec (
        .i_opcode   (i_opcode),
        .i_funct3   (i_funct3),
        .i_funct7_5 (i_funct7_5),
        .o_alu_ctrl (w_alu_ctrl),
        .o_a_sel    (w_a_sel),
        .o_b_sel    (w_b_sel),
        .o_rd_we    (w_rd_we),
        .o_uses_rs2 (w_uses_rs2),
        .o_is_load  (w_is_load),
        .o_illegal  (w_illegal)
    );

`ifdef RVCORE_FWD_EN
    always_comb begin
        w_rs1_val = i_rs1_data;
        if (i_exm_we && i_exm_rd != '0 && i_exm_rd == i_rs1)
            w_rs1_val = i_exm_data;
        else if (i_wb_we && i_wb_rd != '0 && i_wb_rd == i_rs1)
            w_rs1_val = i_wb_data;
    end

    always_comb begin
        w_rs2_val = i_rs2_data;
        if (i_exm_we && i_exm_rd != '0 && i_exm_rd == i_rs2)
            w_rs2_val = i_exm_data;
        else if (i_wb_we && i_wb_rd != '0 && i_wb_rd == i_rs2)
            w_rs2_val = i_wb_data;
    end

    assign w_hazard = r_valid && r_is_load && r_rd != '0 &&
                      (r_rd == i_rs1 || (w_uses_rs2 && r_rd == i_rs2));
`else
    assign w_rs1_val = i_rs1_data;
    assign w_rs2_val = i_rs2_data;
    // Forward and address inputs are kept on the port list but carry no
    // function here; they are folded into a constant-zero hazard term.
    assign w_hazard = 1'b0 & (^{i_exm_we, i_exm_rd, i_exm_data,
                                i_wb_we, i_wb_rd, i_wb_data,
                                i_rs1, i_rs2, w_uses_rs2});
`endif

    assign o_ready  = !i_stall && !w_hazard;
    assign w_accept = i_valid && o_ready;

    always_comb begin
        w_a = w_rs1_val;
        unique case (w_a_sel)
            A_RS1:   w_a = w_rs1_val;
            A_PC:    w_a = i_pc;
            A_ZERO:  w_a = '0;
            default: w_a = w_rs1_val;
        endcase
    end

    always_comb begin
        w_b_raw = i_imm;
        unique case (w_b_sel)
            B_RS2:   w_b_raw = w_rs2_val;
            B_IMM:   w_b_raw = i_imm;
            B_FOUR:  w_b_raw = XLEN'(4);
            default: w_b_raw = i_imm;
        endcase
    end

    always_comb begin
        w_b = w_b_raw;
        if (w_alu_ctrl == ALU_SLL || w_alu_ctrl == ALU_SRL ||
            w_alu_ctrl == ALU_SRA)
            w_b = {{(XLEN-5){1'b0}}, w_b_raw[4:0]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid      <= 1'b0;
            r_alu_ctrl   <= '0;
            r_dataa      <= '0;
            r_datab      <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_rd_we      <= 1'b0;
            r_is_load    <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (i_flush) begin
            r_valid   <= 1'b0;
            r_rd_we   <= 1'b0;
            r_is_load <= 1'b0;
            r_illegal <= 1'b0;
        end else if (i_stall) begin
            r_valid <= r_valid;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_alu_ctrl   <= w_alu_ctrl;
            r_dataa      <= w_a;
            r_datab      <= w_b;
            r_store_data <= w_rs2_val;
            r_rd         <= i_rd;
            r_rd_we      <= w_rd_we && i_rd != '0;
            r_is_load    <= w_is_load;
            r_illegal    <= w_illegal;
        end else begin
            r_valid   <= 1'b0;
            r_rd_we   <= 1'b0;
            r_is_load <= 1'b0;
            r_illegal <= 1'b0;
        end
    end

    assign o_valid      = r_valid;
    assign o_alu_ctrl   = r_alu_ctrl;
    assign o_dataa      = r_dataa;
    assign o_datab      = r_datab;
    assign o_store_data = r_store_data;
    assign o_rd         = r_rd;
    assign o_rd_we      = r_rd_we;
    assign o_is_load    = r_is_load;
    assign o_illegal    = r_illegal;

endmodule
